// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute pipeline stage between decode and memory.
//
// Accepts a decoded instruction over a valid/ready handshake, computes the
// result and holds it in the EX/MEM output register until the memory stage
// takes it. Single-cycle ops load the output register on the accepting edge.
// DIV, when the divider is built in, runs a DW-step restoring divider and
// holds decode off (in_ready low) until the quotient has been written.
// A 2-bit flag register (N, Z) is kept for the branch unit and only changes
// on accepted SUB / SUBI / CMP.
//
// Build option:
//   EX_DIV_EN  defined   -> iterative restoring divider with IDLE/ITER/DONE FSM
//              undefined -> no divider; DIV completes in one cycle with result 0
//                           and div_busy is tied low
//
// Parameters:
//   DW  operand / result width (also the number of divider iterations)
//   RW  destination register index width
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous squash: drops out_valid, aborts a division
//   in_valid/ready  decode handshake
//   in_opcode       5-bit opcode
//   in_a, in_b      operands (in_b already carries the immediate for I-forms)
//   in_rd           destination register
//   out_valid/ready memory-stage handshake
//   out_result      registered result
//   out_rd          registered destination
//   out_opcode      registered opcode
//   flags           [1] = N (signed a < b), [0] = Z (a == b)
//   div_busy        divider is iterating or waiting to write its quotient
// ---------------------------------------------------------------------------
module ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_opcode,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [RW-1:0] in_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [RW-1:0] out_rd,
    output logic [4:0]    out_opcode,
    output logic [1:0]    flags,
    output logic          div_busy
);

    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SUBI = 5'b00101;
    localparam logic [4:0] OP_MUL  = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_ANDI = 5'b01011;
    localparam logic [4:0] OP_OR   = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_NOT  = 5'b01110;
    localparam logic [4:0] OP_XOR  = 5'b10000;
    localparam logic [4:0] OP_XORI = 5'b10001;
    localparam logic [4:0] OP_CMP  = 5'b10010;

    logic          out_valid_reg;
    logic [DW-1:0] out_result_reg;
    logic [RW-1:0] out_rd_reg;
    logic [4:0]    out_opcode_reg;
    logic [1:0]    flags_reg;

    logic          accept;
    logic          single_load;
    logic          is_flag_op;
    logic [DW-1:0] alu_result;

    // The output register can take a new value when it is empty or being
    // drained this cycle.
    assign in_ready = !div_busy && (!out_valid_reg || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    assign is_flag_op = (in_opcode == OP_SUB) || (in_opcode == OP_SUBI) ||
                        (in_opcode == OP_CMP);

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    always_comb begin
        alu_result = in_b;
        case (in_opcode)
            OP_ADD, OP_ADDI:         alu_result = in_a + in_b;
            OP_SUB, OP_SUBI, OP_CMP: alu_result = in_a - in_b;
            OP_MUL:                  alu_result = in_a * in_b;
            OP_AND, OP_ANDI:         alu_result = in_a & in_b;
            OP_OR,  OP_ORI:          alu_result = in_a | in_b;
            OP_XOR, OP_XORI:         alu_result = in_a ^ in_b;
            OP_NOT:                  alu_result = ~in_a;
`ifndef EX_DIV_EN
            OP_DIV:                  alu_result = '0;
`endif
            default:                 alu_result = in_b;
        endcase
    end

`ifdef EX_DIV_EN
    // ------------------------------------------------------------------
    // Restoring divider: the dividend sits in quo_reg and is shifted out
    // MSB first into the partial remainder while quotient bits shift in.
    // A zero divisor never fails the trial subtraction, so the quotient
    // naturally comes out all-ones after the full iteration count.
    // ------------------------------------------------------------------
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } div_state_t;

    div_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [DW-1:0] rem_reg, rem_next;
    logic [DW-1:0] quo_reg, quo_next;
    logic [DW-1:0] dvs_reg, dvs_next;
    logic [RW-1:0] div_rd_reg, div_rd_next;
    logic          div_load;
    logic          is_div;

    logic [DW:0]   rem_shift;
    logic [DW-1:0] rem_diff;
    logic          rem_ge;

    assign is_div = (in_opcode == OP_DIV);

    assign rem_shift = {rem_reg, quo_reg[DW-1]};
    assign rem_ge    = (rem_shift >= {1'b0, dvs_reg});
    // When the trial succeeds the true difference is below the divisor,
    // so the low DW bits of the subtraction are exact.
    assign rem_diff  = rem_shift[DW-1:0] - dvs_reg;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rem_next    = rem_reg;
        quo_next    = quo_reg;
        dvs_next    = dvs_reg;
        div_rd_next = div_rd_reg;
        div_load    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (accept && is_div) begin
                    state_next  = S_ITER;
                    cnt_next    = CW'(DW - 1);
                    rem_next    = '0;
                    quo_next    = in_a;
                    dvs_next    = in_b;
                    div_rd_next = in_rd;
                end
            end
            S_ITER: begin
                if (rem_ge) begin
                    rem_next = rem_diff;
                    quo_next = {quo_reg[DW-2:0], 1'b1};
                end else begin
                    rem_next = rem_shift[DW-1:0];
                    quo_next = {quo_reg[DW-2:0], 1'b0};
                end
                if (cnt_reg == '0) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_DONE: begin
                if (!out_valid_reg || out_ready) begin
                    div_load   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (flush) begin
            state_next = S_IDLE;
            div_load   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvs_reg    <= '0;
            div_rd_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rem_reg    <= rem_next;
            quo_reg    <= quo_next;
            dvs_reg    <= dvs_next;
            div_rd_reg <= div_rd_next;
        end
    end

    assign div_busy    = (state_reg != S_IDLE);
    assign single_load = accept && !is_div;
`else
    assign div_busy    = 1'b0;
    assign single_load = accept;
`endif

    // ------------------------------------------------------------------
    // EX/MEM output register. A load in the same cycle as a consume simply
    // replaces the old result and keeps out_valid high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_rd_reg     <= '0;
            out_opcode_reg <= '0;
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
        end else if (single_load) begin
            out_valid_reg  <= 1'b1;
            out_result_reg <= alu_result;
            out_rd_reg     <= in_rd;
            out_opcode_reg <= in_opcode;
`ifdef EX_DIV_EN
        end else if (div_load) begin
            out_valid_reg  <= 1'b1;
            out_result_reg <= quo_reg;
            out_rd_reg     <= div_rd_reg;
            out_opcode_reg <= OP_DIV;
`endif
        end else if (out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    // Flags track the most recent accepted compare-type op; flush does not
    // roll them back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_reg <= 2'b00;
        end else if (accept && is_flag_op) begin
            flags_reg <= {$signed(in_a) < $signed(in_b), in_a == in_b};
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_rd     = out_rd_reg;
    assign out_opcode = out_opcode_reg;
    assign flags      = flags_reg;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage.
//
// A driver issues directed and random instructions one cycle at a time and,
// for every accepted instruction, pushes the expected result (computed from
// the opcode table with plain arithmetic) into a scoreboard queue. A
// separate monitor checks the DUT outputs against the scoreboard, the
// expected in_ready / div_busy timing and the modelled flag register on
// every falling edge, and pops an entry whenever memory consumes it.
// ---------------------------------------------------------------------------
module tb_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_DIV = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01010;
    localparam logic [4:0] OP_XOR = 5'b10000;
    localparam logic [4:0] OP_CMP = 5'b10010;

`ifdef EX_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_opcode = '0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [RW-1:0] in_rd = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_result;
    logic [RW-1:0] out_rd;
    logic [4:0]    out_opcode;
    logic [1:0]    flags;
    logic          div_busy;

    ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_opcode (out_opcode),
        .flags      (flags),
        .div_busy   (div_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] res;
        logic [RW-1:0] rd;
        logic [4:0]    op;
        int            ready_cyc;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] flags_m = 2'b00;
    int         div_start = -1000;
    int         n_checks = 0;
    int         n_fail = 0;

    // pending effect of the instruction presented in the current cycle
    bit         pend_acc = 1'b0;
    bit         pend_flush = 1'b0;
    bit         pend_flagop = 1'b0;
    bit         pend_div = 1'b0;
    logic [1:0] pend_flags = 2'b00;
    exp_t       pend_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour straight from the opcode table.
    function automatic logic [DW-1:0] model(input logic [4:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        logic [2*DW-1:0] prod;
        case (op)
            5'b00010, 5'b00011:           return a + b;
            5'b00100, 5'b00101, 5'b10010: return a - b;
            5'b00110: begin
                prod = a * b;
                return prod[DW-1:0];
            end
            5'b01010, 5'b01011:           return a & b;
            5'b01100, 5'b01101:           return a | b;
            5'b10000, 5'b10001:           return a ^ b;
            5'b01110:                     return ~a;
            5'b01000: begin
                if (!DIV_EN)  return '0;
                if (b == '0)  return '1;
                return a / b;
            end
            default:                      return b;
        endcase
    endfunction

    function automatic bit exp_valid();
        return (sb.size() > 0) && (cyc >= sb[0].ready_cyc);
    endfunction

    function automatic bit busy_m();
        return DIV_EN && (cyc >= div_start) && (cyc <= div_start + DW);
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    bit mon_ev;
    always @(negedge clk) begin
        if (!rst) begin
            mon_ev = exp_valid();
            check("out_valid", out_valid, mon_ev);
            check("div_busy", div_busy, busy_m());
            check("in_ready", in_ready, !busy_m() && (!mon_ev || out_ready) && !flush);
            check("flags", flags, flags_m);
            if (mon_ev) begin
                check("out_result", out_result, sb[0].res);
                check("out_rd", out_rd, sb[0].rd);
                check("out_opcode", out_opcode, sb[0].op);
                if (out_ready && !flush) void'(sb.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic commit();
        if (pend_flush) begin
            sb.delete();
            div_start = -1000;
        end else if (pend_acc) begin
            if (pend_flagop) flags_m = pend_flags;
            pend_e.ready_cyc = pend_div ? cyc + DW + 1 : cyc;
            if (pend_div) div_start = cyc;
            sb.push_back(pend_e);
        end
        pend_acc   = 1'b0;
        pend_flush = 1'b0;
    endtask

    task automatic step(input bit v, input logic [4:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [RW-1:0] rd,
                        input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        commit();
        in_valid  = v;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_rd     = rd;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        pend_flush = fl;
        pend_acc   = v && in_ready;
        if (pend_acc) begin
            pend_e.res  = model(op, a, b);
            pend_e.rd   = rd;
            pend_e.op   = op;
            pend_div    = DIV_EN && (op == OP_DIV);
            pend_flagop = (op == 5'b00100) || (op == 5'b00101) || (op == 5'b10010);
            pend_flags  = {$signed(a) < $signed(b), a == b};
            $display("txn cyc=%0d op=%05b a=%08h b=%08h rd=%0d expect=%08h",
                     cyc, op, a, b, rd, pend_e.res);
        end
    endtask

    task automatic check_reset_vals();
        check("rst out_valid", out_valid, 0);
        check("rst out_result", out_result, 0);
        check("rst out_rd", out_rd, 0);
        check("rst out_opcode", out_opcode, 0);
        check("rst flags", flags, 0);
        check("rst div_busy", div_busy, 0);
    endtask

    task automatic async_reset(input int hold);
        @(posedge clk);
        #1;
        commit();
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals();
        sb.delete();
        flags_m   = 2'b00;
        div_start = -1000;
        pend_acc  = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 5'd0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    logic [4:0]    r_op;
    logic [DW-1:0] r_a, r_b;

    initial begin
        #12;
        check_reset_vals();
        #10;
        rst = 1'b0;

        // wrap-around add, flags untouched
        step(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd2, 5'd1, 1'b1, 1'b0);
        // compares: less, equal, signed-negative less
        step(1'b1, OP_CMP, 32'd3, 32'd5, 5'd2, 1'b1, 1'b0);
        step(1'b1, OP_CMP, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0);
        step(1'b1, OP_CMP, 32'h8000_0000, 32'd1, 5'd4, 1'b1, 1'b0);
        step(1'b1, OP_SUB, 32'd1, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0);
        idle(2);

        // divides, including divide by zero
        step(1'b1, OP_DIV, 32'd100, 32'd7, 5'd5, 1'b1, 1'b0);
        idle(DW + 3);
        step(1'b1, OP_DIV, 32'd5, 32'd0, 5'd6, 1'b1, 1'b0);
        idle(DW + 3);

        // back-pressure: result held, decode stalled until consumed
        step(1'b1, OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 5'd7, 1'b0, 1'b0);
        repeat (4) step(1'b1, OP_ADD, 32'd9, 32'd9, 5'd8, 1'b0, 1'b0);
        step(1'b1, OP_ADD, 32'd9, 32'd9, 5'd8, 1'b1, 1'b0);
        idle(2);

        // flush ten iterations into a divide, then a plain add
        step(1'b1, OP_DIV, 32'd1000, 32'd3, 5'd9, 1'b1, 1'b0);
        repeat (10) step(1'b0, 5'd0, '0, '0, '0, 1'b1, 1'b0);
        step(1'b1, OP_ADD, 32'd5, 32'd5, 5'd10, 1'b1, 1'b1);
        step(1'b1, OP_ADD, 32'd1, 32'd1, 5'd11, 1'b1, 1'b0);
        idle(2);

        // flush while a result is stalled
        step(1'b1, OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F, 5'd12, 1'b0, 1'b0);
        step(1'b0, 5'd0, '0, '0, '0, 1'b0, 1'b1);
        idle(2);

        // asynchronous reset in the middle of a divide
        step(1'b1, OP_DIV, 32'd12345, 32'd67, 5'd13, 1'b1, 1'b0);
        idle(5);
        async_reset(2);
        step(1'b1, OP_ADD, 32'd20, 32'd22, 5'd14, 1'b1, 1'b0);
        idle(2);

        // random traffic
        repeat (800) begin
            r_op = 5'($urandom_range(0, 31));
            if (r_op == OP_DIV && ($urandom % 4) != 0) r_op = OP_SUB;
            r_a = $urandom;
            case ($urandom % 4)
                0:       r_b = r_a;
                1:       r_b = DW'($urandom_range(0, 15));
                default: r_b = $urandom;
            endcase
            step(($urandom % 4) != 0, r_op, r_a, r_b, 5'($urandom),
                 ($urandom % 4) != 0, ($urandom % 50) == 0);
        end

        idle(DW + 4);
        check("drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
